// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with a pipeline stall request.
// Define DIV_ZERO_FAST_EN to make a zero divisor finish in two cycles through the ZERO state.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               cancel,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ZERO} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               in_zero;

    // quo doubles as the dividend shift register: its MSB feeds the partial remainder
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
        rem_nxt = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (sign_div) begin
                        quo_d   = opa[WIDTH-1] ? -opa : opa;
                        div_d   = opb[WIDTH-1] ? -opb : opb;
                        neg_q_d = opa[WIDTH-1] ^ opb[WIDTH-1];
                        neg_r_d = opa[WIDTH-1];
                    end else begin
                        quo_d   = opa;
                        div_d   = opb;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                    end
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    // Raw dividend is kept so the fast path returns it uncorrected
                    if (opb == '0) begin
                        quo_d   = opa;
                        state_d = ZERO;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = {neg_r_q ? -rem_nxt : rem_nxt,
                                neg_q_q ? -quo_nxt : quo_nxt};
                end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
                result_d = {quo_q, {WIDTH{1'b1}}};
                state_d  = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cancel) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

`ifdef DIV_ZERO_FAST_EN
    assign in_zero = (state_q == ZERO);
`else
    assign in_zero = 1'b0;
`endif

    // Combinational so the divide is held from its very first E cycle
    assign stall  = rst & ~cancel &
                    (((state_q == IDLE) & start) | (state_q == BUSY) | in_zero);
    assign ready  = (state_q == DONE);
    assign result = result_q;

endmodule
